// File: rtl/imem_loader_pkg.sv
// Shared types and sizing constants for the boot-time instruction memory loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, DONE, ERROR} loader_state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects little-endian payload bytes into 32-bit words; word_valid marks the 4th byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam int BI_W = $clog2(BYTES_PER_WORD);

    logic [BI_W-1:0] byte_idx;
    logic [23:0]     lo;

    // Bytes enter at the top and shift down, so after three bytes lo = {b2, b1, b0}.
    assign word_valid = byte_valid && (byte_idx == BI_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            lo       <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            lo       <= '0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 1'b1;
            lo       <= {byte_data, lo[23:8]};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Framed-stream boot loader: length header, packed payload written to imem, XOR checksum gate on core reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);
    localparam int IDX_W = $clog2(IMEM_DEPTH + 1);

    loader_state_t    state;
    logic [LEN_W-1:0] word_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       csum;
    logic             accept;
    logic             rearm;
    logic             word_valid;
    logic [31:0]      word;
    logic [LEN_W-1:0] len_full;

    assign in_ready   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHECK);
    assign accept     = in_valid && in_ready;
    assign rearm      = start && ((state == DONE) || (state == ERROR));
    assign len_full   = {in_data, word_cnt[7:0]};
    assign done       = (state == DONE);
    assign error      = (state == ERROR);
    assign core_reset = (state != DONE);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (rearm),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LEN0;
            word_cnt   <= '0;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (rearm) begin
                state    <= LEN0;
                word_cnt <= '0;
                word_idx <= '0;
                csum     <= '0;
            end else if (accept) begin
                case (state)
                    LEN0: begin
                        word_cnt[7:0] <= in_data;
                        state         <= LEN1;
                    end
                    LEN1: begin
                        word_cnt <= len_full;
                        if (len_full > LEN_W'(IMEM_DEPTH))
                            state <= ERROR;
                        else if (len_full == '0)
                            state <= CHECK;
                        else
                            state <= DATA;
                    end
                    DATA: begin
                        csum <= csum ^ in_data;
                        if (word_valid) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= word;
                            imem_addr  <= ADDR_W'({word_idx, 2'b00});
                            word_idx   <= word_idx + 1'b1;
                            if (LEN_W'(word_idx) + LEN_W'(1) == word_cnt)
                                state <= CHECK;
                        end
                    end
                    CHECK: state <= (in_data == csum) ? DONE : ERROR;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole-frame vectors plus hand sequences for timing, gaps, reset and re-arm.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        start = 1'b0;
    logic        in_ready, imem_we, core_reset, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.IMEM_DEPTH(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    typedef struct {
        int           n;
        logic [159:0] bytes;   // first stream byte in the most significant used position
        bit           exp_done;
        bit           exp_err;
        int           exp_nwr;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready_on_send", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_one_word(input logic [31:0] w, input int gap);
        logic [7:0] cs;
        cs = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        send(8'h01, gap); send(8'h00, gap);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8], gap);
        send(cs, gap);
    endtask

    vec_t vt[7];
    logic [31:0] img[4];
    logic [7:0]  cs4;

    initial begin
        // 2-word payload XOR: 13^05^a0^00 = b6, 93^05^b0^00 = 26, b6^26 = 90
        vt[0] = '{11, 160'h02_00_13_05_a0_00_93_05_b0_00_90, 1'b1, 1'b0, 2, 32'h4, 32'h00B00593};
        vt[1] = '{11, 160'h02_00_13_05_a0_00_93_05_b0_00_39, 1'b0, 1'b1, 2, 32'h4, 32'h00B00593};
        vt[2] = '{3,  160'h00_00_00,                         1'b1, 1'b0, 0, 32'h0, 32'h0};
        vt[3] = '{3,  160'h00_00_01,                         1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[4] = '{2,  160'h41_00,                            1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[5] = '{2,  160'h00_01,                            1'b0, 1'b1, 0, 32'h0, 32'h0};
        // 78^56^34^12 = 08
        vt[6] = '{7,  160'h01_00_78_56_34_12_08,             1'b1, 1'b0, 1, 32'h0, 32'h12345678};

        // Reset values while reset is held
        #1;
        chk("rst_in_ready",   {31'b0, in_ready},   32'd1);
        chk("rst_imem_we",    {31'b0, imem_we},    32'd0);
        chk("rst_imem_addr",  imem_addr,           32'd0);
        chk("rst_imem_wdata", imem_wdata,          32'd0);
        chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rst_done",       {31'b0, done},       32'd0);
        chk("rst_error",      {31'b0, error},      32'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < vt[v].n; i++)
                send(vt[v].bytes[8*(vt[v].n-1-i) +: 8], 0);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_done", v),       {31'b0, done},       {31'b0, vt[v].exp_done});
            chk($sformatf("vec%0d_error", v),      {31'b0, error},      {31'b0, vt[v].exp_err});
            chk($sformatf("vec%0d_core_reset", v), {31'b0, core_reset}, {31'b0, !vt[v].exp_done});
            chk($sformatf("vec%0d_in_ready", v),   {31'b0, in_ready},   32'd0);
            chk($sformatf("vec%0d_nwrites", v),    wr_addr.size(),      vt[v].exp_nwr);
            if (vt[v].exp_nwr > 0 && wr_addr.size() > 0) begin
                chk($sformatf("vec%0d_last_addr", v), wr_addr[wr_addr.size()-1], vt[v].exp_addr);
                chk($sformatf("vec%0d_last_data", v), wr_data[wr_data.size()-1], vt[v].exp_data);
            end
        end

        // Write latency and done timing on the 2-word image
        do_reset();
        for (int i = 0; i < 10; i++) send(vt[0].bytes[8*(10-i) +: 8], 0);
        chk("last_we_latency", {31'b0, imem_we}, 32'd1);
        chk("done_before_cs",  {31'b0, done},    32'd0);
        send(8'h90, 0);
        chk("done_after_cs",       {31'b0, done},       32'd1);
        chk("core_reset_after_cs", {31'b0, core_reset}, 32'd0);
        repeat (2) @(negedge clk);
        chk("two_word_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("two_word_addr0", wr_addr[0], 32'h0);
            chk("two_word_data0", wr_data[0], 32'h00A00513);
            chk("two_word_addr1", wr_addr[1], 32'h4);
            chk("two_word_data1", wr_data[1], 32'h00B00593);
        end

        // 4-word image, back-to-back then with random idle gaps
        img[0] = 32'h00A00513; img[1] = 32'h00B00593; img[2] = 32'h00C58633; img[3] = 32'h0000006F;
        cs4 = 8'h00;
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++) cs4 = cs4 ^ img[w][8*k +: 8];
        for (int run = 0; run < 2; run++) begin
            do_reset();
            send(8'h04, 0);
            send(8'h00, run == 0 ? 0 : int'($urandom_range(0, 5)));
            for (int w = 0; w < 4; w++)
                for (int k = 0; k < 4; k++)
                    send(img[w][8*k +: 8], run == 0 ? 0 : int'($urandom_range(0, 5)));
            send(cs4, run == 0 ? 0 : int'($urandom_range(0, 5)));
            repeat (2) @(negedge clk);
            chk($sformatf("img4_run%0d_done", run), {31'b0, done}, 32'd1);
            chk($sformatf("img4_run%0d_nwr", run),  wr_addr.size(), 32'd4);
            for (int w = 0; w < 4 && w < wr_addr.size(); w++) begin
                chk($sformatf("img4_run%0d_addr%0d", run, w), wr_addr[w], 32'(4*w));
                chk($sformatf("img4_run%0d_data%0d", run, w), wr_data[w], img[w]);
            end
        end

        // Asynchronous reset in the middle of word 0
        do_reset();
        send(8'h02, 0); send(8'h00, 0); send(8'h13, 0); send(8'h05, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready",   {31'b0, in_ready},   32'd1);
        chk("midrst_imem_we",    {31'b0, imem_we},    32'd0);
        chk("midrst_imem_addr",  imem_addr,           32'd0);
        chk("midrst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("midrst_done",       {31'b0, done},       32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        send_one_word(32'h12345678, 0);
        repeat (2) @(negedge clk);
        chk("midrst_reload_done", {31'b0, done}, 32'd1);
        chk("midrst_reload_nwr",  wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("midrst_reload_addr", wr_addr[0], 32'h0);
            chk("midrst_reload_data", wr_data[0], 32'h12345678);
        end

        // start from DONE re-arms; a second image loads
        pulse_start();
        chk("rearm_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rearm_done",       {31'b0, done},       32'd0);
        chk("rearm_in_ready",   {31'b0, in_ready},   32'd1);
        wr_addr.delete();
        wr_data.delete();
        send_one_word(32'h00B50533, 0);
        repeat (2) @(negedge clk);
        chk("rearm_done2", {31'b0, done}, 32'd1);
        chk("rearm_nwr",   wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("rearm_addr", wr_addr[0], 32'h0);
            chk("rearm_data", wr_data[0], 32'h00B50533);
        end

        // start from ERROR re-arms too
        do_reset();
        send(8'h41, 0); send(8'h00, 0);
        pulse_start();
        chk("err_rearm_error", {31'b0, error}, 32'd0);
        chk("err_rearm_ready", {31'b0, in_ready}, 32'd1);

        // start while in LEN1 is ignored
        do_reset();
        send(8'h01, 0);
        pulse_start();
        send(8'h00, 0);
        for (int k = 0; k < 4; k++) send(8'h78 - 8'(k * 8'h22), 0);
        send(8'h08, 0);
        repeat (2) @(negedge clk);
        chk("len1_start_done", {31'b0, done}, 32'd1);
        chk("len1_start_nwr",  wr_addr.size(), 32'd1);
        if (wr_data.size() == 1) chk("len1_start_data", wr_data[0], 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
